dzcpu_useq: RTL and testbench

//  Parametrised microcode sequencer for the dzcpu core. Owns the micro-PC (uPC) and dispatches each

---
 rtl/dzcpu_useq_if.sv | 60 ++++++
 rtl/dzcpu_useq.sv | 148 ++++++++++++++
 tb/tb_dzcpu_useq.sv | 411 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dzcpu_useq_if.sv
`default_nettype none
// ============================================================================
//  Module      : dzcpu_useq_if
//  Description : Bus between the dzcpu core and its microcode sequencer.
//                Carries the opcode/LUT inputs, microcode ROM address/data,
//                stall and Z inputs, and the per-uop strobes.
//                Optional IRQ signals are present only when
//                DZCPU_USEQ_IRQ_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface dzcpu_useq_if #(
    parameter int ADDR_W = 8,
    parameter int UOP_W  = 13
`ifdef DZCPU_USEQ_IRQ_EN
    ,
    parameter int N_IRQ  = 5
`endif
);
    logic [7:0]        iMop;
    logic              iMopValid;
    logic [ADDR_W-1:0] iFlowIdx;
    logic [ADDR_W-1:0] iCbFlowIdx;
    logic [UOP_W-1:0]  iUop;
    logic              iZ;
    logic              iStall;
    logic [ADDR_W-1:0] oUpc;
    logic              oUopValid;
    logic              oPcInc;
    logic              oFlagsUpdate;
    logic              oEof;
    logic              oError;
`ifdef DZCPU_USEQ_IRQ_EN
    logic [N_IRQ-1:0]  iIrqReq;
    logic              iIme;
    logic [N_IRQ-1:0]  oIrqAck;
`endif

    // Sequencer side
    modport slave (
        input  iMop, iMopValid, iFlowIdx, iCbFlowIdx, iUop, iZ, iStall,
        output oUpc, oUopValid, oPcInc, oFlagsUpdate, oEof, oError
`ifdef DZCPU_USEQ_IRQ_EN
        ,
        input  iIrqReq, iIme,
        output oIrqAck
`endif
    );

    // Core / ROM / LUT side
    modport master (
        output iMop, iMopValid, iFlowIdx, iCbFlowIdx, iUop, iZ, iStall,
        input  oUpc, oUopValid, oPcInc, oFlagsUpdate, oEof, oError
`ifdef DZCPU_USEQ_IRQ_EN
        ,
        output iIrqReq, iIme,
        input  oIrqAck
`endif
    );
endinterface
`default_nettype wire

// File: rtl/dzcpu_useq.sv
`default_nettype none
// ============================================================================
//  Module      : dzcpu_useq
//  Description : Microcode sequencer for the dzcpu core. Owns the micro-PC,
//                dispatches opcodes to their flow start index (main LUT, or
//                CB LUT on a JCB uop), steps flows until end-of-flow, honours
//                memory stalls and Z-conditional early exit, and flags a
//                sticky error if the micro-PC runs off the end of the ROM.
//                Define DZCPU_USEQ_IRQ_EN to enable interrupt flow entry on
//                instruction boundaries.
//  Revision    : 1.0 - initial release
// ============================================================================
module dzcpu_useq #(
    parameter int ADDR_W          = 8,
    parameter int UOP_W           = 13,
    parameter int CTRL_W          = 6
`ifdef DZCPU_USEQ_IRQ_EN
    ,
    parameter int N_IRQ           = 5,
    parameter int IRQ_FLOW_BASE   = 170,
    parameter int IRQ_FLOW_STRIDE = 12
`endif
) (
    input  logic        iClock,
    input  logic        iReset,
    dzcpu_useq_if.slave bus
);

    typedef enum logic [0:0] {
        S_DISPATCH = 1'b0,
        S_RUN      = 1'b1
    } state_t;

    // Bit positions inside the control field
    localparam int CB_EOF  = 0;
    localparam int CB_INC  = 1;
    localparam int CB_FU   = 2;
    localparam int CB_COND = 3;
    localparam int CB_CPOL = 4;
    localparam int CB_JCB  = 5;

    localparam logic [ADDR_W-1:0] UPC_LAST = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] upc_q,   upc_d;
    logic              error_q, error_d;

    logic [CTRL_W-1:0] ctrl_w;
    logic              step_w;
    logic              end_w;
    logic              irq_take_w;
    logic [ADDR_W-1:0] irq_flow_w;
    logic              unused_w;

    // The opcode byte only feeds the external LUTs; low uop bits belong to the datapath
    assign unused_w = ^{bus.iMop, bus.iUop};

    assign ctrl_w = bus.iUop[UOP_W-1 -: CTRL_W];

    // A uop executes only in RUN with memory ready; reset suppresses every strobe
    assign step_w = (state_q == S_RUN) && !bus.iStall && !iReset;

    // Unconditional EOF, or COND exit when Z differs from CPOL
    assign end_w = ctrl_w[CB_EOF] | (ctrl_w[CB_COND] & (bus.iZ ^ ctrl_w[CB_CPOL]));

`ifdef DZCPU_USEQ_IRQ_EN
    logic [N_IRQ-1:0] irq_onehot_w;

    // Isolate the lowest pending request line
    assign irq_onehot_w = bus.iIrqReq & (~bus.iIrqReq + N_IRQ'(1));
    assign irq_take_w   = step_w & end_w & bus.iIme & (|bus.iIrqReq);
    assign bus.oIrqAck  = irq_take_w ? irq_onehot_w : '0;

    // Map the winning line to its flow entry point
    always_comb begin
        irq_flow_w = '0;
        for (int k = 0; k < N_IRQ; k++) begin
            if (irq_onehot_w[k]) begin
                irq_flow_w = ADDR_W'(IRQ_FLOW_BASE + k * IRQ_FLOW_STRIDE);
            end
        end
    end
`else
    assign irq_take_w = 1'b0;
    assign irq_flow_w = '0;
`endif

    // Next-state selection: end > JCB > wrap-error > increment
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        error_d = error_q;
        case (state_q)
            S_DISPATCH: begin
                if (bus.iMopValid && !bus.iStall) begin
                    upc_d   = bus.iFlowIdx;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                if (step_w) begin
                    if (end_w) begin
                        // An accepted interrupt chains straight into its flow
                        if (irq_take_w) begin
                            upc_d = irq_flow_w;
                        end else begin
                            state_d = S_DISPATCH;
                        end
                    end else if (ctrl_w[CB_JCB]) begin
                        upc_d = bus.iCbFlowIdx;
                    end else if (upc_q == UPC_LAST) begin
                        // Never fall through into flow 0; abandon and flag
                        error_d = 1'b1;
                        upc_d   = '0;
                        state_d = S_DISPATCH;
                    end else begin
                        upc_d = upc_q + ADDR_W'(1);
                    end
                end
            end
            default: begin
                state_d = S_DISPATCH;
            end
        endcase
    end

    // Sequencer state registers with synchronous reset
    always_ff @(posedge iClock) begin
        if (iReset) begin
            state_q <= S_DISPATCH;
            upc_q   <= '0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            error_q <= error_d;
        end
    end

    assign bus.oUpc         = upc_q;
    assign bus.oUopValid    = step_w;
    assign bus.oPcInc       = step_w & ctrl_w[CB_INC];
    assign bus.oFlagsUpdate = step_w & ctrl_w[CB_FU];
    assign bus.oEof         = step_w & end_w;
    assign bus.oError       = error_q;

endmodule
`default_nettype wire

// File: tb/tb_dzcpu_useq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dzcpu_useq
//  Description : Directed self-checking bench for dzcpu_useq. A behavioural
//                microcode ROM answers oUpc combinationally. Observed vector
//                is {oUpc, oUopValid, oPcInc, oFlagsUpdate, oEof, oError}.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dzcpu_useq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    dzcpu_useq_if #(
        .ADDR_W(8), .UOP_W(13)
`ifdef DZCPU_USEQ_IRQ_EN
        , .N_IRQ(5)
`endif
    ) bus ();

    dzcpu_useq #(
        .ADDR_W(8), .UOP_W(13), .CTRL_W(6)
`ifdef DZCPU_USEQ_IRQ_EN
        , .N_IRQ(5), .IRQ_FLOW_BASE(170), .IRQ_FLOW_STRIDE(12)
`endif
    ) dut (
        .iClock(clk),
        .iReset(rst),
        .bus   (bus)
    );

    // Ctrl field occupies bits 12..7: {JCB, CPOL, COND, FU, INC, EOF}
    localparam logic [12:0] U_EOF  = 13'h0080;
    localparam logic [12:0] U_INC  = 13'h0100;
    localparam logic [12:0] U_FU   = 13'h0200;
    localparam logic [12:0] U_COND = 13'h0400;
    localparam logic [12:0] U_CPOL = 13'h0800;
    localparam logic [12:0] U_JCB  = 13'h1000;

    logic [12:0] rom [256];
    assign bus.iUop = rom[bus.oUpc];

    logic [12:0] obs;
    assign obs = {bus.oUpc, bus.oUopValid, bus.oPcInc, bus.oFlagsUpdate, bus.oEof, bus.oError};

    int vectors     = 0;
    int miscompares = 0;

    // Expected vector: upc and flags {uv, inc, fu, eof, err}
    function automatic logic [12:0] E(input logic [7:0] upc, input logic [4:0] f);
        return {upc, f};
    endfunction

    // Present an opcode for one dispatch cycle; returns at the first RUN cycle
    task automatic dispatch(input logic [7:0] idx);
        bus.iMopValid = 1'b1;
        bus.iFlowIdx  = idx;
        bus.iMop      = idx;
        @(negedge clk);
        bus.iMopValid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL reset_held: observed %h required %h", obs, 13'h0000);
        end
        rst = 1'b0;
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL reset_idle: observed %h required %h", obs, 13'h0000);
        end
        @(negedge clk);
    endtask

    task automatic test_basic_flow();
        logic [12:0] exp [4];
        exp = '{E(8'd26, 5'b11000), E(8'd27, 5'b11000), E(8'd28, 5'b10010), E(8'd28, 5'b00000)};
        dispatch(8'd26);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL basic_flow[%0d]: observed %h required %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_cond_exit();
        logic [12:0] exp_z1 [4];
        logic [12:0] exp_z0 [7];
        logic [12:0] exp_pz0 [2];
        logic [12:0] exp_pz1 [3];
        exp_z1  = '{E(8'd17, 5'b11000), E(8'd18, 5'b11000), E(8'd19, 5'b11010), E(8'd19, 5'b00000)};
        exp_z0  = '{E(8'd17, 5'b11000), E(8'd18, 5'b11000), E(8'd19, 5'b11000), E(8'd20, 5'b11000),
                    E(8'd21, 5'b11000), E(8'd22, 5'b10010), E(8'd22, 5'b00000)};
        exp_pz0 = '{E(8'd70, 5'b11010), E(8'd70, 5'b00000)};
        exp_pz1 = '{E(8'd70, 5'b11000), E(8'd71, 5'b11010), E(8'd71, 5'b00000)};
        bus.iZ = 1'b1;
        dispatch(8'd17);
        for (int i = 0; i < 4; i++) begin
            #1;
            vectors++;
            if (obs !== exp_z1[i]) begin
                miscompares++;
                $display("FAIL cond_z1[%0d]: observed %h required %h", i, obs, exp_z1[i]);
            end
            @(negedge clk);
        end
        bus.iZ = 1'b0;
        dispatch(8'd17);
        for (int i = 0; i < 7; i++) begin
            #1;
            vectors++;
            if (obs !== exp_z0[i]) begin
                miscompares++;
                $display("FAIL cond_z0[%0d]: observed %h required %h", i, obs, exp_z0[i]);
            end
            @(negedge clk);
        end
        dispatch(8'd70);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (obs !== exp_pz0[i]) begin
                miscompares++;
                $display("FAIL cpol_z0[%0d]: observed %h required %h", i, obs, exp_pz0[i]);
            end
            @(negedge clk);
        end
        bus.iZ = 1'b1;
        dispatch(8'd70);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (obs !== exp_pz1[i]) begin
                miscompares++;
                $display("FAIL cpol_z1[%0d]: observed %h required %h", i, obs, exp_pz1[i]);
            end
            @(negedge clk);
        end
        bus.iZ = 1'b0;
    endtask

    task automatic test_prefix();
        logic [12:0] exp [5];
        logic [12:0] exp_p [2];
        exp   = '{E(8'd13, 5'b11000), E(8'd14, 5'b11000), E(8'd15, 5'b11000), E(8'd16, 5'b10110),
                  E(8'd16, 5'b00000)};
        exp_p = '{E(8'd60, 5'b10010), E(8'd60, 5'b00000)};
        bus.iCbFlowIdx = 8'd16;
        dispatch(8'd13);
        for (int i = 0; i < 5; i++) begin
            #1;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL prefix[%0d]: observed %h required %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        // EOF together with JCB must end, not jump
        dispatch(8'd60);
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (obs !== exp_p[i]) begin
                miscompares++;
                $display("FAIL eof_over_jcb[%0d]: observed %h required %h", i, obs, exp_p[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_stall();
        logic [12:0] exp [9];
        logic [12:0] exp_e [4];
        exp   = '{E(8'd48, 5'b11000), E(8'd49, 5'b11000), E(8'd50, 5'b00000), E(8'd50, 5'b00000),
                  E(8'd50, 5'b00000), E(8'd50, 5'b11000), E(8'd51, 5'b11000), E(8'd52, 5'b10010),
                  E(8'd52, 5'b00000)};
        exp_e = '{E(8'd28, 5'b00000), E(8'd28, 5'b00000), E(8'd28, 5'b10010), E(8'd28, 5'b00000)};
        dispatch(8'd48);
        for (int i = 0; i < 9; i++) begin
            bus.iStall = (i >= 2 && i <= 4);
            #1;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL stall_mid[%0d]: observed %h required %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        // Stall over the end cycle: oEof only once, after release
        dispatch(8'd28);
        for (int i = 0; i < 4; i++) begin
            bus.iStall = (i < 2);
            #1;
            vectors++;
            if (obs !== exp_e[i]) begin
                miscompares++;
                $display("FAIL stall_end[%0d]: observed %h required %h", i, obs, exp_e[i]);
            end
            @(negedge clk);
        end
        bus.iStall = 1'b0;
    endtask

    task automatic test_back_to_back();
        logic [12:0] exp [6];
        exp = '{E(8'd28, 5'b10010), E(8'd28, 5'b00000), E(8'd26, 5'b11000), E(8'd27, 5'b11000),
                E(8'd28, 5'b10010), E(8'd28, 5'b00000)};
        bus.iMopValid = 1'b1;
        bus.iFlowIdx  = 8'd28;
        @(negedge clk);
        bus.iFlowIdx  = 8'd26;
        for (int i = 0; i < 6; i++) begin
            if (i == 2) bus.iMopValid = 1'b0;
            #1;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: observed %h required %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        bus.iMopValid = 1'b0;
    endtask

    task automatic test_wrap_error();
        logic [12:0] exp [7];
        exp = '{E(8'd254, 5'b10000), E(8'd255, 5'b10000), E(8'd0, 5'b00001), E(8'd26, 5'b11001),
                E(8'd27, 5'b11001), E(8'd28, 5'b10011), E(8'd28, 5'b00001)};
        dispatch(8'd254);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL wrap[%0d]: observed %h required %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        dispatch(8'd26);
        for (int i = 3; i < 7; i++) begin
            #1;
            vectors++;
            if (obs !== exp[i]) begin
                miscompares++;
                $display("FAIL error_sticky[%0d]: observed %h required %h", i, obs, exp[i]);
            end
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        #1;
        vectors++;
        if (obs !== 13'h0000) begin
            miscompares++;
            $display("FAIL error_clear: observed %h required %h", obs, 13'h0000);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflow();
        bus.iZ = 1'b0;
        dispatch(8'd17);
        #1;
        vectors++;
        if (obs !== E(8'd17, 5'b11000)) begin
            miscompares++;
            $display("FAIL midreset_run: observed %h required %h", obs, E(8'd17, 5'b11000));
        end
        @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if (obs !== E(8'd18, 5'b00000)) begin
            miscompares++;
            $display("FAIL midreset_gated: observed %h required %h", obs, E(8'd18, 5'b00000));
        end
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 2; i++) begin
            #1;
            vectors++;
            if (obs !== 13'h0000) begin
                miscompares++;
                $display("FAIL midreset_idle[%0d]: observed %h required %h", i, obs, 13'h0000);
            end
            @(negedge clk);
        end
    endtask

`ifdef DZCPU_USEQ_IRQ_EN
    task automatic test_irq();
        bus.iIme    = 1'b1;
        bus.iIrqReq = 5'b00110;
        dispatch(8'd28);
        #1;
        vectors++;
        if ({obs, bus.oIrqAck} !== {E(8'd28, 5'b10010), 5'b00010}) begin
            miscompares++;
            $display("FAIL irq_take: observed %h/%b required %h/%b", obs, bus.oIrqAck,
                     E(8'd28, 5'b10010), 5'b00010);
        end
        @(negedge clk);
        bus.iIrqReq = 5'b00000;
        #1;
        vectors++;
        if ({obs, bus.oIrqAck} !== {E(8'd182, 5'b10010), 5'b00000}) begin
            miscompares++;
            $display("FAIL irq_flow: observed %h/%b required %h/%b", obs, bus.oIrqAck,
                     E(8'd182, 5'b10010), 5'b00000);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== E(8'd182, 5'b00000)) begin
            miscompares++;
            $display("FAIL irq_done: observed %h required %h", obs, E(8'd182, 5'b00000));
        end
        @(negedge clk);
        bus.iIme    = 1'b0;
        bus.iIrqReq = 5'b00110;
        dispatch(8'd28);
        #1;
        vectors++;
        if ({obs, bus.oIrqAck} !== {E(8'd28, 5'b10010), 5'b00000}) begin
            miscompares++;
            $display("FAIL irq_masked: observed %h/%b required %h/%b", obs, bus.oIrqAck,
                     E(8'd28, 5'b10010), 5'b00000);
        end
        @(negedge clk);
        #1;
        vectors++;
        if (obs !== E(8'd28, 5'b00000)) begin
            miscompares++;
            $display("FAIL irq_masked_idle: observed %h required %h", obs, E(8'd28, 5'b00000));
        end
        @(negedge clk);
        bus.iIrqReq = 5'b00000;
    endtask
`endif

    initial begin
        for (int a = 0; a < 256; a++) rom[a] = 13'h0000;
        rom[13]  = U_INC;
        rom[14]  = U_INC;
        rom[15]  = U_JCB | U_INC;
        rom[16]  = U_FU | U_EOF;
        rom[17]  = U_INC;
        rom[18]  = U_INC;
        rom[19]  = U_COND | U_INC;
        rom[20]  = U_INC;
        rom[21]  = U_INC;
        rom[22]  = U_EOF;
        rom[26]  = U_INC;
        rom[27]  = U_INC;
        rom[28]  = U_EOF;
        rom[48]  = U_INC;
        rom[49]  = U_INC;
        rom[50]  = U_INC;
        rom[51]  = U_INC;
        rom[52]  = U_EOF;
        rom[60]  = U_JCB | U_EOF;
        rom[70]  = U_COND | U_CPOL | U_INC;
        rom[71]  = U_INC | U_EOF;
        rom[182] = U_EOF;

        rst            = 1'b1;
        bus.iMop       = 8'h00;
        bus.iMopValid  = 1'b0;
        bus.iFlowIdx   = 8'd0;
        bus.iCbFlowIdx = 8'd16;
        bus.iZ         = 1'b0;
        bus.iStall     = 1'b0;
`ifdef DZCPU_USEQ_IRQ_EN
        bus.iIrqReq    = 5'b00000;
        bus.iIme       = 1'b0;
`endif

        test_reset();
        test_basic_flow();
        test_cond_exit();
        test_prefix();
        test_stall();
        test_back_to_back();
        test_wrap_error();
        test_reset_midflow();
`ifdef DZCPU_USEQ_IRQ_EN
        test_irq();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
